// File: rtl/io_bank_fifo.sv
// Processor I/O bank: per-channel inbound and outbound word FIFOs
// with a registered processor read port and sticky error flags.

module io_bank_fifo_ch #(
  parameter int DW    = 28,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when its head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

endmodule

module io_bank_fifo #(
  parameter int NCH   = 4,
  parameter int DW    = 28,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] ext_in_data,
  input  logic [NCH-1:0]    ext_in_valid,
  output logic [NCH-1:0]    ext_in_ready,
  input  logic              proc_req_in,
  input  logic [AW-1:0]     proc_addr_in,
  output logic [DW-1:0]     proc_in_data,
  input  logic              proc_out_en,
  input  logic [AW-1:0]     proc_addr_out,
  input  logic [DW-1:0]     proc_out_data,
  output logic [NCH*DW-1:0] ext_out_data,
  output logic [NCH-1:0]    ext_out_valid,
  input  logic [NCH-1:0]    ext_out_ready,
  output logic [NCH-1:0]    underflow,
  output logic [NCH-1:0]    overflow
);

  logic [NCH-1:0]         rd_hit;
  logic [NCH-1:0]         wr_hit;
  logic [NCH-1:0]         in_full;
  logic [NCH-1:0]         in_empty;
  logic [NCH-1:0]         out_full;
  logic [NCH-1:0]         out_empty;
  logic [NCH-1:0]         out_pop;
  logic [NCH-1:0][DW-1:0] in_head;
  logic [DW-1:0]          rd_word;
  logic                   rd_ok;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    // Out-of-range addresses match no channel and so touch nothing.
    assign rd_hit[k]        = proc_req_in && (proc_addr_in == AW'(k));
    assign wr_hit[k]        = proc_out_en && (proc_addr_out == AW'(k));
    assign ext_in_ready[k]  = !in_full[k];
    assign ext_out_valid[k] = !out_empty[k];
    assign out_pop[k]       = ext_out_ready[k] && !out_empty[k];

    io_bank_fifo_ch #(.DW(DW), .DEPTH(DEPTH)) u_in (
      .clk   (clk),
      .rst   (rst),
      .push  (ext_in_valid[k] && !in_full[k]),
      .din   (ext_in_data[k*DW +: DW]),
      .pop   (rd_hit[k]),
      .dout  (in_head[k]),
      .full  (in_full[k]),
      .empty (in_empty[k])
    );

    io_bank_fifo_ch #(.DW(DW), .DEPTH(DEPTH)) u_out (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_hit[k]),
      .din   (proc_out_data),
      .pop   (out_pop[k]),
      .dout  (ext_out_data[k*DW +: DW]),
      .full  (out_full[k]),
      .empty (out_empty[k])
    );
  end

  assign rd_ok = |(rd_hit & ~in_empty);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_hit[k]) rd_word = in_head[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proc_in_data <= '0;
      underflow    <= '0;
      overflow     <= '0;
    end else begin
      if (rd_ok) proc_in_data <= rd_word;
      underflow <= underflow | (rd_hit & in_empty);
      overflow  <= overflow | (wr_hit & out_full & ~out_pop);
    end
  end

endmodule

// File: tb/tb_io_bank_fifo.sv
// Bench for io_bank_fifo: queue model of every FIFO, read-data
// scoreboard, directed scenarios followed by a random phase.

module tb_io_bank_fifo;

  localparam int NCH   = 4;
  localparam int DW    = 28;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] ext_in_data;
  logic [NCH-1:0]    ext_in_valid;
  logic [NCH-1:0]    ext_in_ready;
  logic              proc_req_in;
  logic [AW-1:0]     proc_addr_in;
  logic [DW-1:0]     proc_in_data;
  logic              proc_out_en;
  logic [AW-1:0]     proc_addr_out;
  logic [DW-1:0]     proc_out_data;
  logic [NCH*DW-1:0] ext_out_data;
  logic [NCH-1:0]    ext_out_valid;
  logic [NCH-1:0]    ext_out_ready;
  logic [NCH-1:0]    underflow;
  logic [NCH-1:0]    overflow;

  always #5 clk = ~clk;

  io_bank_fifo #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .proc_req_in   (proc_req_in),
    .proc_addr_in  (proc_addr_in),
    .proc_in_data  (proc_in_data),
    .proc_out_en   (proc_out_en),
    .proc_addr_out (proc_addr_out),
    .proc_out_data (proc_out_data),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .underflow     (underflow),
    .overflow      (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0]  inq [NCH][$];
  logic [DW-1:0]  outq [NCH][$];
  logic [DW-1:0]  exp_q [$];
  logic [DW-1:0]  pid_m;
  logic [NCH-1:0] uf_m;
  logic [NCH-1:0] ov_m;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < NCH; k++) begin
      chk("in_ready", 64'(ext_in_ready[k]), 64'(inq[k].size() < DEPTH));
      chk("out_valid", 64'(ext_out_valid[k]), 64'(outq[k].size() > 0));
      if (outq[k].size() > 0)
        chk("out_head", 64'(ext_out_data[k*DW +: DW]), 64'(outq[k][0]));
    end
    chk("proc_in_data", 64'(proc_in_data), 64'(pid_m));
    chk("underflow", 64'(underflow), 64'(uf_m));
    chk("overflow", 64'(overflow), 64'(ov_m));
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      inq[k].delete();
      outq[k].delete();
    end
    exp_q.delete();
    pid_m = '0;
    uf_m  = '0;
    ov_m  = '0;
  endtask

  // Apply one clock of the current inputs to the model, then check.
  task automatic tick();
    logic ip, rd, op, wr, acc;
    for (int k = 0; k < NCH; k++) begin
      ip = ext_in_valid[k] && (inq[k].size() < DEPTH);
      rd = proc_req_in && (int'(proc_addr_in) == k);
      if (rd && inq[k].size() > 0) exp_q.push_back(inq[k].pop_front());
      else if (rd) uf_m[k] = 1'b1;
      if (ip) inq[k].push_back(ext_in_data[k*DW +: DW]);
      op  = ext_out_ready[k] && (outq[k].size() > 0);
      wr  = proc_out_en && (int'(proc_addr_out) == k);
      acc = wr && ((outq[k].size() < DEPTH) || op);
      if (op) void'(outq[k].pop_front());
      if (acc) outq[k].push_back(proc_out_data);
      if (wr && !acc) ov_m[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) pid_m = exp_q.pop_front();
    check_outs();
  endtask

  task automatic idle();
    ext_in_valid  = '0;
    proc_req_in   = 1'b0;
    proc_out_en   = 1'b0;
    ext_out_ready = '0;
  endtask

  task automatic push_in(input int ch, input logic [DW-1:0] v);
    ext_in_valid = '0;
    ext_in_valid[ch] = 1'b1;
    ext_in_data[ch*DW +: DW] = v;
    tick();
    idle();
  endtask

  task automatic rd(input int a);
    proc_req_in  = 1'b1;
    proc_addr_in = AW'(a);
    tick();
    idle();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] v,
                    input logic [NCH-1:0] rdy);
    proc_out_en   = 1'b1;
    proc_addr_out = AW'(a);
    proc_out_data = v;
    ext_out_ready = rdy;
    tick();
    idle();
  endtask

  initial begin
    logic [DW-1:0] w [4];
    w[0] = 28'h11; w[1] = 28'h22; w[2] = 28'h33; w[3] = 28'h44;
    rst = 1'b1;
    ext_in_data   = '0;
    proc_addr_in  = '0;
    proc_addr_out = '0;
    proc_out_data = '0;
    idle();
    model_clear();
    @(posedge clk);
    #1;
    check_outs();
    chk("rst_ready", 64'(ext_in_ready), 64'hF);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) push_in(2, w[i]);
    chk("ch2_full", 64'(ext_in_ready), 64'b1011);
    for (int i = 0; i < 4; i++) begin
      rd(2);
      chk("rd_ch2", 64'(proc_in_data), 64'(w[i]));
    end
    chk("ch2_ready", 64'(ext_in_ready), 64'hF);

    rd(1);
    chk("uf_hold", 64'(proc_in_data), 64'h44);
    chk("uf_set", 64'(underflow), 64'b0010);
    tick();
    tick();
    chk("uf_sticky", 64'(underflow), 64'b0010);

    for (int i = 0; i < 4; i++) wr(3, 28'hA1 + 28'(i), '0);
    wr(3, 28'hAA, '0);
    chk("ov_set", 64'(overflow), 64'b1000);
    wr(3, 28'hBB, 4'b1000);
    chk("ov_same", 64'(overflow), 64'b1000);
    chk("out3_head", 64'(ext_out_data[3*DW +: DW]), 64'hA2);
    ext_out_ready = 4'b1000;
    for (int i = 0; i < 4; i++) tick();
    idle();
    chk("out3_drained", 64'(ext_out_valid), 64'h0);

    push_in(0, 28'h01);
    push_in(0, 28'h02);
    ext_in_valid = 4'b0001;
    ext_in_data[0 +: DW] = 28'h55;
    proc_req_in  = 1'b1;
    proc_addr_in = 3'd0;
    tick();
    idle();
    chk("simul_rd", 64'(proc_in_data), 64'h01);
    push_in(0, 28'h66);
    push_in(0, 28'h77);
    chk("ch0_full", 64'(ext_in_ready), 64'b1110);
    for (int i = 0; i < 4; i++) rd(0);
    chk("ch0_last", 64'(proc_in_data), 64'h77);

    push_in(1, 28'h99);
    wr(2, 28'h5A, '0);
    proc_req_in   = 1'b1;
    proc_addr_in  = 3'd5;
    proc_out_en   = 1'b1;
    proc_addr_out = 3'd5;
    proc_out_data = 28'hDEAD;
    tick();
    proc_addr_in  = 3'd4;
    proc_addr_out = 3'd4;
    tick();
    idle();
    chk("oor_pid", 64'(proc_in_data), 64'h77);
    chk("oor_uf", 64'(underflow), 64'b0010);
    chk("oor_ov", 64'(overflow), 64'b1000);
    chk("oor_valid", 64'(ext_out_valid), 64'b0100);

    proc_req_in   = 1'b1;
    proc_addr_in  = 3'd1;
    proc_out_en   = 1'b1;
    proc_addr_out = 3'd1;
    proc_out_data = 28'h3C;
    tick();
    idle();
    chk("rw_same", 64'(proc_in_data), 64'h99);
    chk("rw_valid", 64'(ext_out_valid), 64'b0110);

    push_in(0, 28'h123);
    push_in(3, 28'h456);
    rst = 1'b1;
    #2;
    model_clear();
    check_outs();
    chk("arst_valid", 64'(ext_out_valid), 64'h0);
    ext_in_valid  = '1;
    proc_out_en   = 1'b1;
    proc_addr_out = 3'd0;
    proc_req_in   = 1'b1;
    @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0;
    idle();
    tick();

    for (int c = 0; c < 300; c++) begin
      ext_in_valid = NCH'($urandom);
      for (int k = 0; k < NCH; k++)
        ext_in_data[k*DW +: DW] = DW'($urandom);
      proc_req_in   = 1'($urandom);
      proc_addr_in  = AW'($urandom_range(0, 5));
      proc_out_en   = 1'($urandom);
      proc_addr_out = AW'($urandom_range(0, 5));
      proc_out_data = DW'($urandom);
      ext_out_ready = NCH'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bank_fifo.md
IO_BANK_FIFO -- requirements
Module: io_bank_fifo

Interface
REQ-001 SHALL have parameter NCH, default 4: number of I/O channels, 2..16.
REQ-002 SHALL have parameter DW, default 28: word width (float word of the processor).
REQ-003 SHALL have parameter DEPTH, default 4: per-channel FIFO depth, power of two, 2..64.
REQ-004 SHALL have parameter AW, default clog2(NCH): processor address width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 ext_in_data  input  NCH*DW  inbound words, channel k at bits [k*DW +: DW].
REQ-009 ext_in_valid  input  NCH  per-channel inbound valid.
REQ-010 ext_in_ready  output  NCH  per-channel inbound ready (FIFO not full).
REQ-011 proc_req_in  input  1  processor read strobe.
REQ-012 proc_addr_in  input  AW  channel selected for read.
REQ-013 proc_in_data  output  DW  registered read data to processor.
REQ-014 proc_out_en  input  1  processor write strobe.
REQ-015 proc_addr_out  input  AW  channel selected for write.
REQ-016 proc_out_data  input  DW  write data from processor.
REQ-017 ext_out_data  output  NCH*DW  outbound FIFO heads, packed as REQ-008.
REQ-018 ext_out_valid  output  NCH  per-channel outbound valid (FIFO not empty).
REQ-019 ext_out_ready  input  NCH  per-channel outbound ready.
REQ-020 underflow  output  NCH  sticky: read of empty inbound FIFO.
REQ-021 overflow  output  NCH  sticky: write to full outbound FIFO dropped.

Function
REQ-022 SHALL contain NCH inbound and NCH outbound FIFOs, each DEPTH words, with count width clog2(DEPTH)+1 and pointers wrapping modulo DEPTH.
REQ-023 Inbound push on channel k SHALL occur on a cycle with ext_in_valid[k] && ext_in_ready[k]; ext_in_ready[k] = !full.
REQ-024 Processor read: a cycle with proc_req_in=1, addr<NCH, FIFO non-empty SHALL pop that FIFO; proc_in_data SHALL show the popped word on the next cycle (latency 1) and hold until the next successful read.
REQ-025 Read of an empty inbound FIFO SHALL not pop, SHALL leave proc_in_data unchanged, and SHALL set underflow[k] the next cycle.
REQ-026 Inbound simultaneous push and processor pop SHALL both take effect; count unchanged.
REQ-027 Processor write: proc_out_en=1, addr<NCH SHALL push proc_out_data into outbound FIFO k unless full.
REQ-028 Write to a full outbound FIFO SHALL be accepted if ext_out_ready[k] pops that same cycle; otherwise dropped and overflow[k] set the next cycle.
REQ-029 Outbound pop SHALL occur on ext_out_valid[k] && ext_out_ready[k]; ext_out_data[k] SHALL be the current head (first-word fall-through); content undefined when valid=0.
REQ-030 Address >= NCH on read or write SHALL be ignored: no pop, push, flag change or data change.
REQ-031 Simultaneous read and write strobes, same or different channel, SHALL be independent.
REQ-032 underflow/overflow bits SHALL clear only on reset.

Reset
REQ-033 rst=1 SHALL immediately clear all counts and pointers, proc_in_data=0, underflow=0, overflow=0; thus ext_in_ready=all 1, ext_out_valid=all 0.
REQ-034 Reset asserted mid-transfer SHALL discard all FIFO contents; no push or pop SHALL occur on the cycle rst deasserts if rst is still high at that edge.

Verification
REQ-035 NCH=4, DEPTH=4: push 0x11,0x22,0x33,0x44 into ch2 -> ext_in_ready[2]=0 after 4th; four reads addr=2 return 0x11..0x44 each one cycle later; ready returns to 1.
REQ-036 Read addr=1 with ch1 empty -> proc_in_data unchanged, underflow=4'b0010 next cycle and stays set.
REQ-037 Fill outbound ch3 with 4 words, ext_out_ready[3]=0, 5th write 0xAA -> dropped, overflow[3]=1; repeat with ext_out_ready[3]=1 same cycle -> accepted, overflow unchanged.
REQ-038 Inbound ch0 with 2 words, simultaneous push 0x55 and read -> count stays 2, FIFO order preserved.
REQ-039 Write/read with addr=5 on NCH=4, AW=3 -> no state change anywhere.
REQ-040 Assert rst with FIFOs half full -> all outputs at reset values immediately, without a clock edge.
